// File: rtl/reg_dump_scanner_if.sv
// Register-dump beat stream: one (id, value) beat per valid/ready handshake.
// The master holds every field stable while dump_valid is high and dump_ready is low.
interface reg_dump_scanner_if;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_id;
    logic [31:0] dump_data;
    logic        dump_last;

    modport master (
        output dump_valid,
        output dump_id,
        output dump_data,
        output dump_last,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_id,
        input  dump_data,
        input  dump_last,
        output dump_ready
    );
endinterface

// File: rtl/reg_dump_scanner.sv
// Sweeps the Mips register-observation port and emits one (id, value) beat per register; SETTLE+1 cycles
// per register at full rate, beat held while dump_ready is low. REG_DUMP_DIFF_EN suppresses unchanged registers.
module reg_dump_scanner #(
    parameter int NUM_REGS = 32,
    parameter int SETTLE   = 1,
    parameter int CNT_W    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 continuous_i,
    output logic [4:0]           reg_out_id_o,
    input  logic [31:0]          reg_out_data_i,
    reg_dump_scanner_if.master   dump,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_W-1:0]     sweep_count_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SELECT = 2'd1;
    localparam logic [1:0] S_SEND   = 2'd2;

    localparam logic [4:0] LAST_ID     = 5'(NUM_REGS - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    logic [1:0]       state_q, state_d;
    logic [4:0]       idx_q, idx_d;
    logic [3:0]       settle_q, settle_d;
    logic             vld_q, vld_d;
    logic [4:0]       id_q, id_d;
    logic [31:0]      data_q, data_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] sweep_q, sweep_d;
    logic             advance;
    logic             skip;

`ifdef REG_DUMP_DIFF_EN
    logic [31:0]         shadow_q [NUM_REGS];
    logic [NUM_REGS-1:0] shadow_vld_q;

    // A register matching the value last delivered to the consumer carries no news.
    assign skip = shadow_vld_q[idx_q] && (shadow_q[idx_q] == reg_out_data_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_vld_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (vld_q && dump.dump_ready) begin
            shadow_q[id_q]     <= data_q;
            shadow_vld_q[id_q] <= 1'b1;
        end
    end
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        vld_d    = vld_q;
        id_d     = id_q;
        data_d   = data_q;
        last_d   = last_q;
        done_d   = 1'b0;
        sweep_d  = sweep_q;
        advance  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_SELECT;
                    idx_d    = '0;
                    settle_d = '0;
                end
            end
            S_SELECT: begin
                if (settle_q == SETTLE_LAST) begin
                    if (skip) begin
                        advance = 1'b1;
                    end else begin
                        vld_d   = 1'b1;
                        id_d    = idx_q;
                        data_d  = reg_out_data_i;
                        last_d  = (idx_q == LAST_ID);
                        state_d = S_SEND;
                    end
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            S_SEND: begin
                if (vld_q && dump.dump_ready) begin
                    vld_d   = 1'b0;
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Shared by a real handshake and a skipped capture so both end a sweep identically.
        if (advance) begin
            settle_d = '0;
            if (idx_q != LAST_ID) begin
                idx_d   = idx_q + 5'd1;
                state_d = S_SELECT;
            end else begin
                done_d  = 1'b1;
                sweep_d = sweep_q + {{(CNT_W-1){1'b0}}, 1'b1};
                idx_d   = '0;
                state_d = continuous_i ? S_SELECT : S_IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            vld_q    <= 1'b0;
            id_q     <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            sweep_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            vld_q    <= vld_d;
            id_q     <= id_d;
            data_q   <= data_d;
            last_q   <= last_d;
            done_q   <= done_d;
            sweep_q  <= sweep_d;
        end
    end

    assign reg_out_id_o   = idx_q;
    assign dump.dump_valid = vld_q;
    assign dump.dump_id    = id_q;
    assign dump.dump_data  = data_q;
    assign dump.dump_last  = last_q;
    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = done_q;
    assign sweep_count_o  = sweep_q;

endmodule

// File: tb/tb_reg_dump_scanner.sv
// Bench for reg_dump_scanner: a Mips register model feeds the DUT and a queue of expected beats
// is filled when each sweep is launched and drained by a monitor on every handshake.
module tb_reg_dump_scanner;

    typedef struct packed {
        logic [4:0]  id;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        continuous;
    logic [4:0]  reg_out_id;
    logic [31:0] reg_out_data;
    logic        busy;
    logic        done;
    logic [15:0] sweep_count;
    logic [31:0] mips_r [32];

    reg_dump_scanner_if dif ();

    reg_dump_scanner dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .continuous_i   (continuous),
        .reg_out_id_o   (reg_out_id),
        .reg_out_data_i (reg_out_data),
        .dump           (dif),
        .busy_o         (busy),
        .done_o         (done),
        .sweep_count_o  (sweep_count)
    );

    assign reg_out_data = mips_r[reg_out_id];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    total = 0;
    int    bad = 0;
    int    beats = 0;
    int    last_seen = 0;
    int    done_seen = 0;
    beat_t exp_q[$];
    beat_t mon_e;

    // Scoreboard: a handshake completes at the next rising edge whenever valid && ready at the falling edge.
    always @(negedge clk) begin
        if (!rst && dif.dump_valid && dif.dump_ready) begin
            beats++;
            if (dif.dump_last) last_seen++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_beat id=%0d data=%0d last=%0d", dif.dump_id, dif.dump_data, dif.dump_last);
            end else begin
                mon_e = exp_q.pop_front();
                if (dif.dump_id !== mon_e.id || dif.dump_data !== mon_e.data || dif.dump_last !== mon_e.last) begin
                    bad++;
                    $display("FAIL beat got id=%0d data=%0d last=%0d want id=%0d data=%0d last=%0d",
                             dif.dump_id, dif.dump_data, dif.dump_last, mon_e.id, mon_e.data, mon_e.last);
                end
            end
        end
        if (!rst && done) done_seen++;
    end

    task automatic load_regs();
        for (int i = 0; i < 32; i++) mips_r[i] = 32'(i * 3);
    endtask

    task automatic push_sweep();
        beat_t b;
        for (int i = 0; i < 32; i++) begin
            b.id   = 5'(i);
            b.data = mips_r[i];
            b.last = (i == 31);
            exp_q.push_back(b);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        start = 1'b0;
        continuous = 1'b0;
        dif.dump_ready = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        beats = 0;
        last_seen = 0;
        done_seen = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        continuous = 1'b0;
        dif.dump_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (dif.dump_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sweep_count !== 16'd0 ||
            reg_out_id !== 5'd0 || dif.dump_id !== 5'd0 || dif.dump_data !== 32'd0 || dif.dump_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_state valid=%0b busy=%0b done=%0b cnt=%0d id_sel=%0d dump_id=%0d data=%0d last=%0b want all 0",
                     dif.dump_valid, busy, done, sweep_count, reg_out_id, dif.dump_id, dif.dump_data, dif.dump_last);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_sweep();
        do_reset();
        load_regs();
        push_sweep();
        pulse_start();
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || dif.dump_valid !== 1'b0) begin
            bad++;
            $display("FAIL sweep_after_start busy=%0b valid=%0b want busy=1 valid=0", busy, dif.dump_valid);
        end
        for (int e = 1; e <= 64; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 1) begin
                total++;
                if (dif.dump_valid !== 1'b1 || dif.dump_id !== 5'd0) begin
                    bad++;
                    $display("FAIL first_beat_latency valid=%0b id=%0d want valid=1 id=0", dif.dump_valid, dif.dump_id);
                end
            end
            if (e == 63) begin
                total++;
                if (done !== 1'b0) begin
                    bad++;
                    $display("FAIL done_early done=%0b want 0 after edge 63", done);
                end
            end
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || sweep_count !== 16'd1) begin
            bad++;
            $display("FAIL sweep_end done=%0b busy=%0b cnt=%0d want done=1 busy=0 cnt=1", done, busy, sweep_count);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || exp_q.size() != 0 || beats != 32 || last_seen != 1) begin
            bad++;
            $display("FAIL sweep_totals done=%0b left=%0d beats=%0d lasts=%0d want 0 0 32 1",
                     done, exp_q.size(), beats, last_seen);
        end
    endtask

    task automatic test_backpressure();
        bit found;
        bit ok;
        do_reset();
        load_regs();
        push_sweep();
        pulse_start();
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(posedge clk); #1;
            if (busy && reg_out_id == 5'd5 && !dif.dump_valid) begin
                dif.dump_ready = 1'b0;
                found = 1'b1;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL bp_reach_id5 reached=0 want 1");
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (c == 3) mips_r[5] = 32'd999;
            @(negedge clk);
            total++;
            if (dif.dump_valid !== 1'b1 || dif.dump_id !== 5'd5 || dif.dump_data !== 32'd15) begin
                bad++;
                $display("FAIL bp_hold cycle=%0d valid=%0b id=%0d data=%0d want 1 5 15",
                         c, dif.dump_valid, dif.dump_id, dif.dump_data);
            end
        end
        @(posedge clk); #1;
        dif.dump_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk); #1;
            if (dif.dump_valid && dif.dump_id != 5'd5) found = 1'b1;
        end
        total++;
        if (!found || dif.dump_id !== 5'd6) begin
            bad++;
            $display("FAIL bp_next_beat seen=%0b id=%0d want id=6", found, dif.dump_id);
        end
        wait_idle(200, ok);
        total++;
        if (!ok || exp_q.size() != 0 || sweep_count !== 16'd1) begin
            bad++;
            $display("FAIL bp_end idle=%0b left=%0d cnt=%0d want 1 0 1", ok, exp_q.size(), sweep_count);
        end
    endtask

    task automatic test_continuous();
        bit ok;
        int want_beats;
        do_reset();
        load_regs();
        continuous = 1'b1;
        push_sweep();
`ifdef REG_DUMP_DIFF_EN
        want_beats = 32;
`else
        push_sweep();
        push_sweep();
        want_beats = 96;
`endif
        pulse_start();
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (done_seen == 2) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (5) @(posedge clk);
        #1 continuous = 1'b0;
        total++;
        if (!ok || busy !== 1'b1) begin
            bad++;
            $display("FAIL cont_two_sweeps reached=%0b busy=%0b want 1 1", ok, busy);
        end
        wait_idle(400, ok);
        repeat (5) @(posedge clk);
        @(negedge clk);
        total++;
        if (!ok || busy !== 1'b0 || done_seen != 3 || sweep_count !== 16'd3 || beats != want_beats || exp_q.size() != 0) begin
            bad++;
            $display("FAIL cont_end idle=%0b busy=%0b dones=%0d cnt=%0d beats=%0d left=%0d want 1 0 3 3 %0d 0",
                     ok, busy, done_seen, sweep_count, beats, exp_q.size(), want_beats);
        end
    endtask

    task automatic test_reset_mid_beat();
        bit found;
        bit ok;
        beat_t b;
        do_reset();
        load_regs();
        for (int i = 0; i < 17; i++) begin
            b.id = 5'(i);
            b.data = mips_r[i];
            b.last = 1'b0;
            exp_q.push_back(b);
        end
        pulse_start();
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(posedge clk); #1;
            if (busy && reg_out_id == 5'd17 && !dif.dump_valid) begin
                dif.dump_ready = 1'b0;
                found = 1'b1;
            end
        end
        for (int c = 0; c < 20 && found && !dif.dump_valid; c++) begin
            @(posedge clk); #1;
        end
        total++;
        if (!found || dif.dump_valid !== 1'b1 || dif.dump_id !== 5'd17) begin
            bad++;
            $display("FAIL rst_mid_reach reached=%0b valid=%0b id=%0d want 1 1 17", found, dif.dump_valid, dif.dump_id);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (dif.dump_valid !== 1'b0 || busy !== 1'b0 || reg_out_id !== 5'd0 || sweep_count !== 16'd0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL rst_mid_async valid=%0b busy=%0b id_sel=%0d cnt=%0d left=%0d want 0 0 0 0 0",
                     dif.dump_valid, busy, reg_out_id, sweep_count, exp_q.size());
        end
        @(posedge clk); #1;
        rst = 1'b0;
        dif.dump_ready = 1'b1;
        exp_q.delete();
        beats = 0;
        done_seen = 0;
        last_seen = 0;
        push_sweep();
        pulse_start();
        wait_idle(200, ok);
        total++;
        if (!ok || exp_q.size() != 0 || beats != 32 || sweep_count !== 16'd1) begin
            bad++;
            $display("FAIL rst_mid_restart idle=%0b left=%0d beats=%0d cnt=%0d want 1 0 32 1",
                     ok, exp_q.size(), beats, sweep_count);
        end
    endtask

    task automatic test_start_while_busy();
        bit found;
        bit ok;
        do_reset();
        load_regs();
        push_sweep();
        pulse_start();
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(posedge clk); #1;
            if (reg_out_id == 5'd10) found = 1'b1;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(200, ok);
        repeat (6) @(posedge clk);
        @(negedge clk);
        total++;
        if (!found || !ok || busy !== 1'b0 || done_seen != 1 || beats != 32 || exp_q.size() != 0 || sweep_count !== 16'd1) begin
            bad++;
            $display("FAIL start_busy reached=%0b idle=%0b busy=%0b dones=%0d beats=%0d left=%0d cnt=%0d want 1 1 0 1 32 0 1",
                     found, ok, busy, done_seen, beats, exp_q.size(), sweep_count);
        end
    endtask

`ifdef REG_DUMP_DIFF_EN
    task automatic test_diff();
        bit ok;
        beat_t b;
        do_reset();
        load_regs();
        push_sweep();
        pulse_start();
        wait_idle(200, ok);
        total++;
        if (!ok || beats != 32 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL diff_first idle=%0b beats=%0d left=%0d want 1 32 0", ok, beats, exp_q.size());
        end
        mips_r[7] = 32'h0000_BEEF;
        b.id = 5'd7;
        b.data = 32'h0000_BEEF;
        b.last = 1'b0;
        exp_q.push_back(b);
        beats = 0;
        last_seen = 0;
        done_seen = 0;
        pulse_start();
        wait_idle(200, ok);
        @(negedge clk);
        total++;
        if (!ok || beats != 1 || last_seen != 0 || done_seen != 1 || sweep_count !== 16'd2 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL diff_second idle=%0b beats=%0d lasts=%0d dones=%0d cnt=%0d left=%0d want 1 1 0 1 2 0",
                     ok, beats, last_seen, done_seen, sweep_count, exp_q.size());
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        start = 1'b0;
        continuous = 1'b0;
        dif.dump_ready = 1'b1;
        load_regs();
        test_reset();
        test_single_sweep();
        test_backpressure();
        test_continuous();
        test_reset_mid_beat();
        test_start_while_busy();
`ifdef REG_DUMP_DIFF_EN
        test_diff();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
